w_serializer: RTL and testbench

Upstream feeder for the serial sequence-detector FSMs. Accepts parallel words over a valid/ready handshake and shifts each one out MSB-first as the single-bit `w` stream, one bit per clock, with a qualifying strobe. An optional parity bit can follow the data, and a programmable idle gap separates frames, so the detector sees realistic framed traffic. The detector's `w` input connects to `w_o`.

---
 rtl/ser_pkg.sv | 14 +
 rtl/w_serializer.sv | 128 ++++++++++++
 tb/tb_w_serializer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and parameter limits for the w serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } ser_state_e;

  localparam int unsigned DATA_W_MAX  = 32;
  localparam int unsigned GAP_CYC_MAX = 15;

endpackage

// File: rtl/w_serializer.sv
// Parallel-to-serial framer feeding the sequence detectors, MSB first with a gap between frames.
// Define W_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module w_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clk_i,
  input  logic              res_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              w_o,
  output logic              w_valid_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int unsigned     CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DATA_W);
  localparam logic [3:0]      GapLoad = 4'(GAP_CYC);

  if (DATA_W < 2 || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("w_serializer: DATA_W out of range");
  end
  if (GAP_CYC > GAP_CYC_MAX) begin : g_bad_gap_cyc
    $error("w_serializer: GAP_CYC out of range");
  end

  ser_state_e        state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0]        gap_q;
  logic              ready_q;
  logic              w_q;
  logic              w_valid_q;
  logic              done_q;
`ifdef W_SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      ready_q   <= 1'b0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef W_SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      // Serial outputs idle low unless a frame bit is emitted below.
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (valid_i && ready_q) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
`ifdef W_SERIALIZER_PARITY_EN
            par_q   <= ^data_i;
`endif
          end
        end
        SHIFT: begin
          w_q       <= shreg_q[DATA_W-1];
          w_valid_q <= 1'b1;
          shreg_q   <= shreg_q << 1;
          if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
`ifdef W_SERIALIZER_PARITY_EN
            state_q <= PARITY;
`else
            done_q <= 1'b1;
            if (GapLoad == 4'd0) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= GAP;
              gap_q   <= GapLoad;
            end
`endif
          end
        end
`ifdef W_SERIALIZER_PARITY_EN
        PARITY: begin
          w_q       <= par_q;
          w_valid_q <= 1'b1;
          done_q    <= 1'b1;
          if (GapLoad == 4'd0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= GAP;
            gap_q   <= GapLoad;
          end
        end
`endif
        GAP: begin
          gap_q <= gap_q - 4'd1;
          // ready_o is registered, so raise it on the edge that lands in IDLE.
          if (gap_q <= 4'd1) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign w_o       = w_q;
  assign w_valid_o = w_valid_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_w_serializer.sv
// Directed self-checking bench for w_serializer: framing, gap, back-to-back, reset, detector hookup.
module tb_w_serializer;

`ifdef W_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       res_n;
  logic [7:0] data;
  logic       valid;
  logic       ready, w, wv, done, busy;
  logic [7:0] data0;
  logic       valid0;
  logic       ready0, w0, wv0, done0, busy0;

  int n_cmp = 0;
  int n_err = 0;

  w_serializer #(.DATA_W(8), .GAP_CYC(2)) dut (
    .clk_i     (clk),
    .res_ni    (res_n),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .w_o       (w),
    .w_valid_o (wv),
    .done_o    (done),
    .busy_o    (busy)
  );

  w_serializer #(.DATA_W(8), .GAP_CYC(0)) dut0 (
    .clk_i     (clk),
    .res_ni    (res_n),
    .data_i    (data0),
    .valid_i   (valid0),
    .ready_o   (ready0),
    .w_o       (w0),
    .w_valid_o (wv0),
    .done_o    (done0),
    .busy_o    (busy0)
  );

  // Minimal "1101" detector standing in for the downstream FSM.
  logic [3:0] hist;
  logic       z;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)  hist <= 4'd0;
    else if (wv) hist <= {hist[2:0], w};
  end
  assign z = (hist == 4'b1101);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame on dut (GAP_CYC=2): accept, all frame bits, gap, back to ready.
  task automatic run_frame(input logic [7:0] word, input bit chk_z);
    data  = word;
    valid = 1'b1;
    tick();
    chk("acc_ready", 32'(ready), 32'd0);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_wv", 32'(wv), 32'd0);
    valid = 1'b0;
    data  = ~word;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("bit%0d_w", i), 32'(w), 32'(word[7-i]));
      chk($sformatf("bit%0d_wv", i), 32'(wv), 32'd1);
      chk($sformatf("bit%0d_done", i), 32'(done), 32'((i == 7) && (P == 0)));
      if (chk_z) chk($sformatf("bit%0d_z", i), 32'(z), 32'd0);
    end
    if (P == 1) begin
      tick();
      chk("par_w", 32'(w), 32'(^word));
      chk("par_wv", 32'(wv), 32'd1);
      chk("par_done", 32'(done), 32'd1);
      if (chk_z) chk("z_hit", 32'(z), 32'd1);
    end
    for (int g = 0; g < 2; g++) begin
      tick();
      if (chk_z && P == 0 && g == 0) chk("z_hit", 32'(z), 32'd1);
      chk($sformatf("gap%0d_wv", g), 32'(wv), 32'd0);
      chk($sformatf("gap%0d_w", g), 32'(w), 32'd0);
      chk($sformatf("gap%0d_ready", g), 32'(ready), 32'(g == 1));
      chk($sformatf("gap%0d_busy", g), 32'(busy), 32'(g != 1));
    end
  endtask

  initial begin
    res_n  = 1'b0;
    data   = 8'h00;
    valid  = 1'b0;
    data0  = 8'h00;
    valid0 = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_wv", 32'(wv), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    res_n = 1'b1;
    #1;
    chk("rel_ready_pre", 32'(ready), 32'd0);
    tick();
    chk("rel_ready", 32'(ready), 32'd1);
    chk("rel_wv", 32'(wv), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // Framing, parity 0 then 1 when enabled
    run_frame(8'hA5, 1'b0);
    run_frame(8'h07, 1'b0);

    // Back-to-back on GAP_CYC=0 with valid held high
    chk("b2b_ready0", 32'(ready0), 32'd1);
    data0  = 8'h81;
    valid0 = 1'b1;
    tick();
    chk("b2b_acc1", 32'(ready0), 32'd0);
    data0 = 8'h5A;
    for (int i = 0; i < 8 + P; i++) begin
      tick();
      chk($sformatf("b2b1_w%0d", i), 32'(w0),
          (i < 8) ? 32'(8'h81 >> (7 - i)) & 32'd1 : 32'(^8'h81));
      chk($sformatf("b2b1_wv%0d", i), 32'(wv0), 32'd1);
    end
    chk("b2b_ready_back", 32'(ready0), 32'd1);
    chk("b2b_done_last", 32'(done0), 32'd1);
    tick();
    chk("b2b_acc2", 32'(ready0), 32'd0);
    chk("b2b_acc2_wv", 32'(wv0), 32'd0);
    data0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("b2b2_w%0d", i), 32'(w0), 32'(8'h5A >> (7 - i)) & 32'd1);
    end
    valid0 = 1'b0;
    for (int i = 0; i < P + 1; i++) tick();
    chk("b2b_idle", 32'(ready0), 32'd1);

    // Reset pulse at data bit 4
    data  = 8'hFF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_w", 32'(w), 32'd1);
    chk("pre_rst_wv", 32'(wv), 32'd1);
    res_n = 1'b0;
    #1;
    chk("async_w", 32'(w), 32'd0);
    chk("async_wv", 32'(wv), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    tick();
    res_n = 1'b1;
    tick();
    chk("rerel_ready", 32'(ready), 32'd1);
    chk("rerel_wv", 32'(wv), 32'd0);
    run_frame(8'h3C, 1'b0);

    // Detector sees 1101 completing on the last data bit
    run_frame(8'h0D, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
